// File: rtl/btn_press_decoder_pkg.sv
// Shared definitions for the button press decoder and its tick counter.
// State encodings, the default divider tick constant and a busy helper.
package btn_press_decoder_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRESS1 = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_PRESS2 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_PRESS1 = S_PRESS1,
    ST_HOLD   = S_HOLD,
    ST_GAP    = S_GAP,
    ST_PRESS2 = S_PRESS2
  } state_e;

  // CLK cycles per CE tick, shared with the debounce filter.
  localparam int unsigned DFLT_TICK_DIV = 50000;

  function automatic logic busy_of(input state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/btn_press_decoder_tick_counter.sv
// CE-gated tick counter with synchronous clear and terminal flag.
// Ports: clk, rst (async high), ce_i, clr_i, last_i (N-1), at_o.
module btn_tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             at_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (ce_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // "At N": the CE that would take the count to N.
  assign at_o = ce_i && (cnt_q == last_i);

endmodule

// File: rtl/btn_press_decoder.sv
// Classifies debounced button gestures into short/long/double pulses.
// Ports: CLK, RST, CE, BTN_I in; SHORT_O, LONG_O, DOUBLE_O, BUSY_O out.
// Optional macro BTN_AUTOREPEAT_EN: repeat LONG_O while held.
module btn_press_decoder
  import btn_press_decoder_pkg::*;
#(
  parameter int LONG_TICKS    = 200,
  parameter int DBL_GAP_TICKS = 60,
  parameter int REPEAT_TICKS  = 50,
  parameter int CNT_W         = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic CE,
  input  logic BTN_I,
  output logic SHORT_O,
  output logic LONG_O,
  output logic DOUBLE_O,
  output logic BUSY_O
);

  state_e state_q, state_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic dbl_q, dbl_d;
  logic busy_q, busy_d;

  logic [CNT_W-1:0] last;
  logic rep_hit;
  logic cnt_ce;
  logic cnt_clr;
  logic at;

  // Counter only runs in states that time something.
  always_comb begin
    cnt_ce = 1'b0;
    unique case (1'b1)
      state_q == ST_PRESS1: cnt_ce = CE;
      state_q == ST_GAP:    cnt_ce = CE;
`ifdef BTN_AUTOREPEAT_EN
      state_q == ST_HOLD:   cnt_ce = CE;
`endif
      default:              cnt_ce = 1'b0;
    endcase
  end

  assign cnt_clr = (state_d != state_q) || rep_hit;

  btn_tick_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (CLK),
    .rst    (RST),
    .ce_i   (cnt_ce),
    .clr_i  (cnt_clr),
    .last_i (last),
    .at_o   (at)
  );

  // Level changes are tested before the terminal count so they win.
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    rep_hit = 1'b0;
    last    = CNT_W'(LONG_TICKS - 1);
    unique case (state_q)
      ST_IDLE: begin
        if (BTN_I)
          state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        last = CNT_W'(LONG_TICKS - 1);
        if (!BTN_I) begin
          state_d = ST_GAP;
        end else if (at) begin
          long_d  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        last = CNT_W'(REPEAT_TICKS - 1);
        if (!BTN_I) begin
          state_d = ST_IDLE;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (at) begin
          long_d  = 1'b1;
          rep_hit = 1'b1;
        end
`endif
      end
      ST_GAP: begin
        last = CNT_W'(DBL_GAP_TICKS - 1);
        if (BTN_I) begin
          dbl_d   = 1'b1;
          state_d = ST_PRESS2;
        end else if (at) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (!BTN_I)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = busy_of(state_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      busy_q  <= busy_d;
    end
  end

  assign SHORT_O  = short_q;
  assign LONG_O   = long_q;
  assign DOUBLE_O = dbl_q;
  assign BUSY_O   = busy_q;

endmodule

// File: tb/tb_btn_press_decoder.sv
// Directed bench for btn_press_decoder.
// LONG=8, GAP=4, REPEAT=3 ticks; CE every 4 CLK.
module tb_btn_press_decoder;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic btn;
  logic short_o, long_o, dbl_o, busy_o;

  always #5 clk = ~clk;

  btn_press_decoder #(
    .LONG_TICKS    (8),
    .DBL_GAP_TICKS (4),
    .REPEAT_TICKS  (3),
    .CNT_W         (8)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .CE       (ce),
    .BTN_I    (btn),
    .SHORT_O  (short_o),
    .LONG_O   (long_o),
    .DOUBLE_O (dbl_o),
    .BUSY_O   (busy_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ce_n = 0;
  int ce_div = 0;
  int short_cnt, long_cnt, dbl_cnt, multi;
  int short_ce, long_ce, long_last_ce, dbl_cyc;
  int base, mark, exp_long_cnt, exp_long_last;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    short_cnt = 0; long_cnt = 0; dbl_cnt = 0; multi = 0;
    short_ce = -1; long_ce = -1; long_last_ce = -1; dbl_cyc = -1;
  endtask

  // One CLK: drive at negedge, sample 1 time unit after posedge.
  task automatic step(input logic b);
    @(negedge clk);
    btn = b;
    ce = (ce_div == 3);
    ce_div = (ce_div + 1) % 4;
    if (ce) ce_n++;
    @(posedge clk);
    #1;
    cyc++;
    if (short_o === 1'b1) begin
      short_cnt++;
      short_ce = ce_n;
    end
    if (long_o === 1'b1) begin
      long_cnt++;
      if (long_cnt == 1) long_ce = ce_n;
      long_last_ce = ce_n;
    end
    if (dbl_o === 1'b1) begin
      dbl_cnt++;
      dbl_cyc = cyc;
    end
    if (int'(short_o) + int'(long_o) + int'(dbl_o) > 1) multi++;
  endtask

  task automatic ticks(input int n, input logic b);
    repeat (4 * n) step(b);
  endtask

  int all_multi = 0;

  initial begin
    rst = 1'b0;
    btn = 1'b0;
    ce = 1'b0;
    clr_stats();
    #2 rst = 1'b1;
    #1;
    chk("rst_short", int'(short_o), 0);
    chk("rst_long", int'(long_o), 0);
    chk("rst_dbl", int'(dbl_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    repeat (4) step(1'b0);
    rst = 1'b0;
    ticks(1, 1'b0);

    // Short press: 3 ticks high, SHORT_O on 4th tick after release
    clr_stats();
    base = ce_n;
    ticks(3, 1'b1);
    chk("short_busy_in", int'(busy_o), 1);
    ticks(6, 1'b0);
    chk("short_cnt", short_cnt, 1);
    chk("short_when", short_ce, base + 3 + 4);
    chk("short_nolong", long_cnt + dbl_cnt, 0);
    chk("short_busy_out", int'(busy_o), 0);
    all_multi += multi;

    // Long press: 20 ticks high
    clr_stats();
    base = ce_n;
    ticks(20, 1'b1);
    ticks(2, 1'b0);
`ifdef BTN_AUTOREPEAT_EN
    exp_long_cnt = 5;
    exp_long_last = base + 20;
`else
    exp_long_cnt = 1;
    exp_long_last = base + 8;
`endif
    chk("long_first", long_ce, base + 8);
    chk("long_cnt", long_cnt, exp_long_cnt);
    chk("long_last", long_last_ce, exp_long_last);
    chk("long_noshort", short_cnt + dbl_cnt, 0);
    all_multi += multi;

    // Double click: 2 high, 2 low, 10 high
    clr_stats();
    ticks(2, 1'b1);
    ticks(2, 1'b0);
    mark = cyc + 1;
    ticks(10, 1'b1);
    ticks(6, 1'b0);
    chk("dbl_cnt", dbl_cnt, 1);
    chk("dbl_when", dbl_cyc, mark);
    chk("dbl_noshort", short_cnt, 0);
    chk("dbl_nolong", long_cnt, 0);
    all_multi += multi;

    // Gap boundary: release exactly 4 ticks, then a fresh press
    clr_stats();
    ticks(2, 1'b1);
    base = ce_n;
    ticks(4, 1'b0);
    mark = ce_n;
    ticks(9, 1'b1);
    ticks(2, 1'b0);
    chk("gap_short", short_cnt, 1);
    chk("gap_short_when", short_ce, base + 4);
    chk("gap_nodbl", dbl_cnt, 0);
    chk("gap_newpress_long", long_ce, mark + 8);
    all_multi += multi;

    // Release on the same CLK as the 8th CE
    clr_stats();
    ticks(7, 1'b1);
    repeat (3) step(1'b1);
    step(1'b0);
    mark = ce_n;
    ticks(6, 1'b0);
    chk("sim_nolong", long_cnt, 0);
    chk("sim_short", short_cnt, 1);
    chk("sim_short_when", short_ce, mark + 4);
    all_multi += multi;

    // Reset in the middle of GAP
    clr_stats();
    ticks(2, 1'b1);
    ticks(2, 1'b0);
    chk("rgap_busy_pre", int'(busy_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("rgap_busy", int'(busy_o), 0);
    chk("rgap_outs", int'(short_o) + int'(long_o) + int'(dbl_o), 0);
    repeat (4) step(1'b0);
    rst = 1'b0;
    ticks(8, 1'b0);
    chk("rgap_noshort", short_cnt, 0);
    chk("rgap_idle", int'(busy_o), 0);
    all_multi += multi;

    chk("onehot", all_multi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_press_decoder.md
Name: btn_press_decoder

Overview:
- Downstream stage of the button debounce filter: consumes the filter's debounced level and the shared divider tick CE.
- Classifies each gesture as a short press, a long press or a double click.
- Emits one-CLK command pulses to the control FSM.
- Timing is measured in CE ticks, so it scales with the same divider as the filter.

Parameters:
- LONG_TICKS, 200, CE ticks a press must be held to count as long (>=2)
- DBL_GAP_TICKS, 60, CE ticks after release in which a second press makes a double click (>=2)
- REPEAT_TICKS, 50, CE ticks between auto-repeat LONG_O pulses (used only with the optional feature)
- CNT_W, 8, tick counter width; 2^CNT_W must exceed max(LONG_TICKS, DBL_GAP_TICKS, REPEAT_TICKS)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- CE  in  1  divider tick, one CLK wide
- BTN_I  in  1  debounced button level from the filter; synchronous to CLK, no internal synchroniser
- SHORT_O  out  1  one-CLK pulse: short press recognised
- LONG_O  out  1  one-CLK pulse: long press recognised (and auto-repeat)
- DOUBLE_O  out  1  one-CLK pulse: double click recognised
- BUSY_O  out  1  high whenever FSM is not IDLE

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high. On RST: FSM=IDLE, counter=0, SHORT_O/LONG_O/DOUBLE_O/BUSY_O=0.
- Outputs: all outputs are registered. A pulse is high for exactly one CLK, in the cycle after the CLK edge that sampled the causing condition. At most one pulse output is high in any cycle.
- Counter: CNT_W bits, cleared on every state change, increments only on CE.
- Terminal condition: the counter is "at N" when CE=1 and CNT==N-1.
- Priority: a BTN_I level change beats CE in the same cycle (transition taken, counter cleared, no terminal action).
- IDLE: BTN_I=1 -> PRESS1.
- PRESS1:
  - BTN_I=0 -> GAP.
  - Counter at LONG_TICKS -> pulse LONG_O, go HOLD.
- HOLD: BTN_I=0 -> IDLE.
- GAP:
  - BTN_I=1 -> pulse DOUBLE_O, go PRESS2.
  - Counter at DBL_GAP_TICKS -> pulse SHORT_O, go IDLE.
- PRESS2: BTN_I=0 -> IDLE. No long detection; holding the second press never yields LONG_O.
- Consequences:
  - A short press reports SHORT_O only after the gap window expires.
  - A double click reports DOUBLE_O on the second press edge and no SHORT_O.
- CE stuck low: the FSM waits indefinitely with no pulses. Edges are still tracked.
- Reset mid-gesture: any pending gesture is discarded and no pulse is emitted. After RST deasserts with BTN_I already high, IDLE enters PRESS1 on the first edge.
- Counter never wraps: the terminal compare always fires first, given the CNT_W rule.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: in HOLD, the counter runs on CE. At REPEAT_TICKS it pulses LONG_O and clears, repeating until BTN_I=0.
- Undefined: HOLD ignores CE, LONG_O fires once per press, and REPEAT_TICKS is unused.

Decomposition:
- Shared package: state encodings IDLE/PRESS1/HOLD/GAP/PRESS2 as 3-bit localparams, and a default-tick constant shared with the filter.
- Sub-module btn_tick_counter: CE-gated counter with synchronous clear and a terminal-count output `at(N)`, parameterised by CNT_W. The FSM instantiates it once.

Test Plan:
Setup for all scenarios: LONG_TICKS=8, DBL_GAP_TICKS=4, REPEAT_TICKS=3, CE every 4 CLK.
- Short press: BTN_I high 3 ticks, then low -> SHORT_O single pulse 4 ticks after release; no other pulses; BUSY_O low afterwards.
- Long press: BTN_I high 20 ticks -> LONG_O pulse at tick 8 of press, nothing further. With BTN_AUTOREPEAT_EN: additional pulses at ticks 11, 14, 17, 20.
- Double click: high 2 ticks, low 2 ticks, high 10 ticks -> DOUBLE_O one CLK after second rise; no SHORT_O and no LONG_O.
- Gap boundary: release held exactly 4 ticks before the second press -> SHORT_O at the 4th tick, then the second press is treated as a new PRESS1.
- Simultaneous events: BTN_I falls on the same CLK as the 8th CE in PRESS1 -> goes GAP, no LONG_O, SHORT_O later.
- Reset mid-GAP: assert RST -> all outputs 0 immediately; no SHORT_O after deassert.
